// File: rtl/led_pattern_gen_pkg.sv
// Shared definitions for the LED pattern generator: pattern mode codes,
// triangle direction states and default sizing.
package led_pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_SAW    = 2'b00,
    MODE_TRI    = 2'b01,
    MODE_MIRROR = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DIV_W = 16;

endpackage

// File: rtl/led_pattern_gen_tick_prescaler.sv
// Programmable prescaler: asserts step for one enabled cycle every div+1
// enabled cycles. Reusable by PWM blocks.
module tick_prescaler
  import led_pattern_gen_pkg::*;
#(
  parameter int unsigned DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             step
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_terminal;

  // >= rather than == so that lowering div below the running count fires at once
  assign w_terminal = (r_cnt >= div);
  assign step       = en & ~clear & w_terminal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_terminal ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED brightness-pattern generator: prescaled level sequencer producing
// sawtooth, triangle, mirror or held levels with tick/wrap strobes.
module led_pattern_gen
  import led_pattern_gen_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] value,
  output logic             tick,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX = '1;

  mode_e            r_mode;
  dir_e             r_dir;
  logic [WIDTH:0]   r_phase;
  logic [WIDTH-1:0] r_value;
  logic             r_tick;
  logic             r_wrap;

  mode_e            w_mode_in;
  logic             w_mode_chg;
  logic             w_clear;
  logic             w_step;
  logic [WIDTH:0]   w_phase_nxt;

  assign w_mode_in   = mode_e'(mode);
  // A mode switch restarts the pattern exactly as an explicit clear does
  assign w_mode_chg  = (w_mode_in != r_mode);
  assign w_clear     = clear | w_mode_chg;
  assign w_phase_nxt = r_phase + 1'b1;

  tick_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clear (w_clear),
    .div   (div),
    .step  (w_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode  <= MODE_SAW;
      r_dir   <= DIR_UP;
      r_phase <= '0;
      r_value <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_mode <= w_mode_in;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      if (w_clear) begin
        r_dir   <= DIR_UP;
        r_phase <= '0;
        r_value <= '0;
      end else if (w_step) begin
        r_tick <= 1'b1;
        case (r_mode)
          MODE_SAW: begin
            r_value <= r_value + 1'b1;
            r_wrap  <= (r_value == MAX);
          end
          MODE_TRI: begin
            if (r_dir == DIR_UP) begin
              if (r_value == MAX) begin
                r_dir   <= DIR_DOWN;
                r_value <= MAX - 1'b1;
              end else begin
                r_value <= r_value + 1'b1;
              end
            end else begin
              if (r_value == '0) begin
                r_dir   <= DIR_UP;
                r_value <= {{(WIDTH-1){1'b0}}, 1'b1};
                r_wrap  <= 1'b1;
              end else begin
                r_value <= r_value - 1'b1;
              end
            end
          end
          MODE_MIRROR: begin
            // Second half of the phase folds back, so each endpoint shows twice
            r_phase <= w_phase_nxt;
            r_value <= w_phase_nxt[WIDTH] ? ~w_phase_nxt[WIDTH-1:0]
                                          : w_phase_nxt[WIDTH-1:0];
            r_wrap  <= &r_phase;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign value = r_value;
  assign tick  = r_tick;
  assign wrap  = r_wrap;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed self-checking bench for led_pattern_gen (WIDTH=8, DIV_W=16).
module tb_led_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        clear;
  logic [1:0]  mode;
  logic [15:0] div;
  logic [7:0]  value;
  logic        tick;
  logic        wrap;

  int n_vec = 0;
  int n_err = 0;

  led_pattern_gen #(
    .WIDTH (8),
    .DIV_W (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clear (clear),
    .mode  (mode),
    .div   (div),
    .value (value),
    .tick  (tick),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p;
    int v;
    int exp_v;
    int frozen;
    logic exp_t;

    rst = 1'b1; en = 1'b0; clear = 1'b0; mode = 2'b00; div = 16'd0;
    cyc(); cyc();
    chk("rst_value", 32'(value), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_wrap", 32'(wrap), 0);
    rst = 1'b0;
    cyc();
    chk("idle_value", 32'(value), 0);

    // SAW, div=0: step every cycle, single wrap at 255->0
    en = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      cyc();
      chk("saw_value", 32'(value), 32'(i % 256));
      chk("saw_tick", 32'(tick), 1);
      chk("saw_wrap", 32'(wrap), (i == 256) ? 1 : 0);
    end

    // TRI, div=0: the mode switch cycle clears, then 0..255..0 and up again
    mode = 2'b01;
    cyc();
    chk("tri_chg_value", 32'(value), 0);
    chk("tri_chg_tick", 32'(tick), 0);
    for (int k = 1; k <= 512; k++) begin
      cyc();
      p = k % 510;
      v = (p <= 255) ? p : 510 - p;
      chk("tri_value", 32'(value), 32'(v));
      chk("tri_wrap", 32'(wrap), (k == 511) ? 1 : 0);
    end

    // MIRROR, div=0: endpoints held two steps, wrap at phase 511->0
    mode = 2'b10;
    cyc();
    chk("mir_chg_value", 32'(value), 0);
    chk("mir_chg_tick", 32'(tick), 0);
    for (int k = 1; k <= 513; k++) begin
      cyc();
      p = k % 512;
      v = (p < 256) ? p : 511 - p;
      chk("mir_value", 32'(value), 32'(v));
      chk("mir_wrap", 32'(wrap), (k == 512) ? 1 : 0);
    end

    // SAW, div=3 then lowered to 1 while the count sits at 2
    mode = 2'b00; div = 16'd3;
    cyc();
    chk("div_chg_tick", 32'(tick), 0);
    exp_v = 0;
    for (int j = 1; j <= 16; j++) begin
      cyc();
      exp_t = (j <= 10) ? ((j % 4) == 0) : ((j % 2) == 1);
      if (exp_t) exp_v++;
      chk("div_tick", 32'(tick), 32'(exp_t));
      chk("div_value", 32'(value), 32'(exp_v));
      if (j == 10) div = 16'd1;
    end

    // TRI down to 100, then switch to SAW with div=2
    mode = 2'b01; div = 16'd0;
    cyc();
    for (int k = 1; k <= 410; k++) cyc();
    chk("tri100_value", 32'(value), 100);
    mode = 2'b00; div = 16'd2;
    cyc();
    chk("sw_saw_value", 32'(value), 0);
    chk("sw_saw_tick", 32'(tick), 0);
    for (int j = 1; j <= 3; j++) begin
      cyc();
      chk("sw_saw_tick_j", 32'(tick), (j == 3) ? 1 : 0);
      chk("sw_saw_value_j", 32'(value), (j == 3) ? 1 : 0);
    end

    // Same TRI state, restarted by clear instead; direction must come back UP
    mode = 2'b01; div = 16'd0;
    cyc();
    for (int k = 1; k <= 410; k++) cyc();
    chk("tri100b_value", 32'(value), 100);
    clear = 1'b1; div = 16'd2;
    cyc();
    clear = 1'b0;
    chk("clr_value", 32'(value), 0);
    chk("clr_tick", 32'(tick), 0);
    for (int j = 1; j <= 7; j++) begin
      cyc();
      chk("clr_tick_j", 32'(tick), ((j % 3) == 0) ? 1 : 0);
      chk("clr_wrap_j", 32'(wrap), 0);
      chk("clr_value_j", 32'(value), 32'(j / 3));
    end

    // en low for 50 cycles with count=1, value=2: everything frozen
    en = 1'b0;
    frozen = 2;
    for (int j = 1; j <= 50; j++) begin
      cyc();
      chk("frz_value", 32'(value), 32'(frozen));
      chk("frz_tick", 32'(tick), 0);
      chk("frz_wrap", 32'(wrap), 0);
    end
    en = 1'b1;
    cyc();
    chk("resume1_tick", 32'(tick), 0);
    chk("resume1_value", 32'(value), 2);
    cyc();
    chk("resume2_tick", 32'(tick), 1);
    chk("resume2_value", 32'(value), 3);

    // clear still acts with en low
    en = 1'b0; clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("clr_en0_value", 32'(value), 0);

    // Async reset mid-cycle, then first tick div+1 cycles after release
    en = 1'b1;
    for (int j = 1; j <= 7; j++) cyc();
    chk("pre_rst_value", 32'(value), 2);
    #3;
    rst = 1'b1; mode = 2'b00;
    #1;
    chk("async_rst_value", 32'(value), 0);
    chk("async_rst_tick", 32'(tick), 0);
    cyc();
    rst = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      cyc();
      chk("post_rst_tick", 32'(tick), (j == 3) ? 1 : 0);
      chk("post_rst_value", 32'(value), (j == 3) ? 1 : 0);
    end

    // HOLD, div=1: tick every 2 cycles, value and wrap static
    mode = 2'b11; div = 16'd1;
    cyc();
    chk("hold_chg_value", 32'(value), 0);
    for (int j = 1; j <= 8; j++) begin
      cyc();
      chk("hold_tick", 32'(tick), ((j % 2) == 0) ? 1 : 0);
      chk("hold_value", 32'(value), 0);
      chk("hold_wrap", 32'(wrap), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
